// File: rtl/jtag_loader_if.sv
// Purpose: bundles the JTAG word-load input, chain pass-through and both memory write ports.
// Latency: none, wiring only.
// Backpressure: none; Jen is a plain per-cycle enable.
//
// Ports (slave view, as seen by the loader):
//   Jen, Jin                              load enable and word in
//   Jout                                  Jin delayed one cycle
//   dmem_we/dmem_addr/dmem_wdata          data memory write port
//   imem_we/imem_addr/imem_wdata          instruction memory write port
//   core_hold, load_done                  ownership and completion status
interface jtag_loader_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 9
);
    logic             Jen;
    logic [WIDTH-1:0] Jin;
    logic [WIDTH-1:0] Jout;
    logic             dmem_we;
    logic [AW-1:0]    dmem_addr;
    logic [WIDTH-1:0] dmem_wdata;
    logic             imem_we;
    logic [AW-1:0]    imem_addr;
    logic [WIDTH-1:0] imem_wdata;
    logic             core_hold;
    logic             load_done;

    // Driver side: supplies the word stream and observes the loader.
    modport master (
        output Jen, Jin,
        input  Jout, dmem_we, dmem_addr, dmem_wdata,
        input  imem_we, imem_addr, imem_wdata, core_hold, load_done
    );

    // Loader side.
    modport slave (
        input  Jen, Jin,
        output Jout, dmem_we, dmem_addr, dmem_wdata,
        output imem_we, imem_addr, imem_wdata, core_hold, load_done
    );
endinterface

// File: rtl/jtag_loader.sv
// Purpose: streams JTAG words into data memory then instruction memory, each filled top-down.
// Latency: one cycle from word acceptance to write strobe; Jout is Jin delayed one cycle.
// Backpressure: none; Jen=0 pauses the load with state and counter held.
//
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous active-low reset, priority over everything
//   bus   jtag_loader_if slave modport (Jen/Jin in; Jout, memory write ports,
//         core_hold and load_done out)
module jtag_loader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          rst,
    jtag_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_D = 2'd1,
        LOAD_I = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t           state, state_nxt;
    logic [AW-1:0]    cnt, cnt_nxt;
    logic             jen_q;

    logic             dmem_we_q, dmem_we_nxt;
    logic [AW-1:0]    dmem_addr_q, dmem_addr_nxt;
    logic [WIDTH-1:0] dmem_wdata_q, dmem_wdata_nxt;
    logic             imem_we_q, imem_we_nxt;
    logic [AW-1:0]    imem_addr_q, imem_addr_nxt;
    logic [WIDTH-1:0] imem_wdata_q, imem_wdata_nxt;
    logic [WIDTH-1:0] jout_q;

    // Descending fill: word k of either memory lands at DEPTH-1-k.
    logic [AW-1:0]    wr_addr;
    assign wr_addr = LAST - cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            jen_q        <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            jout_q       <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            jen_q        <= bus.Jen;
            dmem_we_q    <= dmem_we_nxt;
            dmem_addr_q  <= dmem_addr_nxt;
            dmem_wdata_q <= dmem_wdata_nxt;
            imem_we_q    <= imem_we_nxt;
            imem_addr_q  <= imem_addr_nxt;
            imem_wdata_q <= imem_wdata_nxt;
            jout_q       <= bus.Jin;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        dmem_we_nxt    = 1'b0;
        dmem_addr_nxt  = dmem_addr_q;
        dmem_wdata_nxt = dmem_wdata_q;
        imem_we_nxt    = 1'b0;
        imem_addr_nxt  = imem_addr_q;
        imem_wdata_nxt = imem_wdata_q;

        case (state)
            // cnt is zero here, so the first word goes to the top address.
            IDLE: begin
                if (bus.Jen) begin
                    dmem_we_nxt    = 1'b1;
                    dmem_addr_nxt  = wr_addr;
                    dmem_wdata_nxt = bus.Jin;
                    cnt_nxt        = cnt + AW'(1);
                    state_nxt      = LOAD_D;
                end
            end
            LOAD_D: begin
                if (bus.Jen) begin
                    dmem_we_nxt    = 1'b1;
                    dmem_addr_nxt  = wr_addr;
                    dmem_wdata_nxt = bus.Jin;
                    if (cnt == LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = LOAD_I;
                    end else begin
                        cnt_nxt   = cnt + AW'(1);
                    end
                end
            end
            LOAD_I: begin
                if (bus.Jen) begin
                    imem_we_nxt    = 1'b1;
                    imem_addr_nxt  = wr_addr;
                    imem_wdata_nxt = bus.Jin;
                    if (cnt == LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt   = cnt + AW'(1);
                    end
                end
            end
            // Only a fresh Jen edge restarts; a Jen level held over from the
            // final word must not trigger a second load.
            DONE: begin
                if (bus.Jen && !jen_q) begin
                    dmem_we_nxt    = 1'b1;
                    dmem_addr_nxt  = wr_addr;
                    dmem_wdata_nxt = bus.Jin;
                    cnt_nxt        = cnt + AW'(1);
                    state_nxt      = LOAD_D;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.Jout       = jout_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_wdata = dmem_wdata_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.core_hold  = (state != DONE);
    assign bus.load_done  = (state == DONE);

endmodule

// File: tb/tb_jtag_loader.sv
// Purpose: self-checking bench for jtag_loader against a word-count reference model.
// Latency: model predicts outputs one cycle after each driven input.
// Backpressure: not applicable; Jen is driven directly.
module tb_jtag_loader;

    localparam int WIDTH = 32;
    localparam int DEPTH = 512;
    localparam int AW    = 9;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    jtag_loader_if #(.WIDTH(WIDTH), .AW(AW)) jif ();

    jtag_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (jif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: number of words accepted in the current load
    // (2*DEPTH means the load is complete) and Jen from the previous cycle.
    int           words;
    bit           prev_en;
    bit           e_rst;
    bit           e_dwe, e_iwe;
    int           e_daddr, e_iaddr;
    logic [31:0]  e_dwd, e_iwd, e_jout;

    logic [31:0]  mem_d [DEPTH];
    logic [31:0]  mem_i [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit en, input logic [31:0] din);
        rst     = r;
        jif.Jen = en;
        jif.Jin = din;
        @(posedge clk);
        e_dwe = 1'b0;
        e_iwe = 1'b0;
        e_rst = !r;
        if (!r) begin
            words   = 0;
            prev_en = 1'b0;
            e_jout  = '0;
            e_daddr = 0;
            e_iaddr = 0;
            e_dwd   = '0;
            e_iwd   = '0;
        end else begin
            e_jout = din;
            if (en && (words < 2*DEPTH || !prev_en)) begin
                if (words == 2*DEPTH) words = 0;
                if (words < DEPTH) begin
                    e_dwe   = 1'b1;
                    e_daddr = DEPTH - 1 - words;
                    e_dwd   = din;
                end else begin
                    e_iwe   = 1'b1;
                    e_iaddr = DEPTH - 1 - (words - DEPTH);
                    e_iwd   = din;
                end
                words++;
            end
            prev_en = en;
        end
        #1;
        check("jout", jif.Jout, e_jout);
        check("dmem_we", 32'(jif.dmem_we), 32'(e_dwe));
        check("imem_we", 32'(jif.imem_we), 32'(e_iwe));
        check("load_done", 32'(jif.load_done), 32'(words == 2*DEPTH));
        check("core_hold", 32'(jif.core_hold), 32'(words != 2*DEPTH));
        if (e_dwe || e_rst) begin
            check("dmem_addr", 32'(jif.dmem_addr), 32'(e_daddr));
            check("dmem_wdata", jif.dmem_wdata, e_dwd);
        end
        if (e_iwe || e_rst) begin
            check("imem_addr", 32'(jif.imem_addr), 32'(e_iaddr));
            check("imem_wdata", jif.imem_wdata, e_iwd);
        end
        if (jif.dmem_we === 1'b1) mem_d[jif.dmem_addr] = jif.dmem_wdata;
        if (jif.imem_we === 1'b1) mem_i[jif.imem_addr] = jif.imem_wdata;
    endtask

    initial begin
        rst     = 1'b0;
        jif.Jen = 1'b0;
        jif.Jin = '0;
        words   = 0;
        prev_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = 32'hFFFF_FFFF;
            mem_i[i] = 32'hFFFF_FFFF;
        end

        // Reset values, then Jout pass-through while idle.
        repeat (3) step(1'b0, 1'b1, $urandom);
        step(1'b1, 1'b0, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 32'h1234_5678);

        // Full load with Jin = word index.
        for (int i = 0; i < 2*DEPTH; i++) step(1'b1, 1'b1, 32'(i));
        for (int i = 0; i < DEPTH; i++) begin
            check("dmem_content", mem_d[DEPTH-1-i], 32'(i));
            check("imem_content", mem_i[DEPTH-1-i], 32'(i + DEPTH));
        end

        // Jen held high in DONE is ignored; Jout still passes through.
        step(1'b1, 1'b1, 32'hDEAD_BEEF);
        repeat (4) step(1'b1, 1'b1, $urandom);
        // A fresh Jen edge restarts the load at the top data address.
        step(1'b1, 1'b0, $urandom);
        step(1'b1, 1'b1, 32'hCAFE_0001);
        check("restart_addr", 32'(jif.dmem_addr), 32'(DEPTH - 1));
        check("restart_done", 32'(jif.load_done), 32'd0);

        // Pause after word 100, then resume.
        step(1'b0, 1'b0, '0);
        for (int i = 0; i <= 100; i++) step(1'b1, 1'b1, $urandom);
        repeat (5) step(1'b1, 1'b0, $urandom);
        step(1'b1, 1'b1, 32'h0000_0101);
        check("resume_addr", 32'(jif.dmem_addr), 32'd410);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, $urandom);

        // Reset in the middle of a load at word 300, then reload.
        step(1'b0, 1'b0, '0);
        for (int i = 0; i <= 300; i++) step(1'b1, 1'b1, $urandom);
        step(1'b0, 1'b1, $urandom);
        step(1'b1, 1'b1, 32'h0BAD_F00D);
        check("reload_addr", 32'(jif.dmem_addr), 32'(DEPTH - 1));

        // Random traffic with occasional pauses and resets.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 1499) != 0, $urandom_range(0, 9) < 8, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_loader.md
JTAG_LOADER -- requirements
Module: jtag_loader

Interface
REQ-001 Parameter: WIDTH, 32, word width of Jin/Jout and memory write data.
REQ-002 Parameter: DEPTH, 512, words per memory (data memory, then instruction memory).
REQ-003 Parameter: AW, 9, memory address width; SHALL equal log2(DEPTH).
REQ-004 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-005 Port: rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-006 Port: Jen  input  1  load enable; one word is presented on Jin per cycle while high.
REQ-007 Port: Jin  input  WIDTH  serial-word load data.
REQ-008 Port: Jout  output  WIDTH  Jin delayed by one cycle (chain pass-through).
REQ-009 Port: dmem_we  output  1  data memory write strobe.
REQ-010 Port: dmem_addr  output  AW  data memory write address.
REQ-011 Port: dmem_wdata  output  WIDTH  data memory write data.
REQ-012 Port: imem_we  output  1  instruction memory write strobe.
REQ-013 Port: imem_addr  output  AW  instruction memory write address.
REQ-014 Port: imem_wdata  output  WIDTH  instruction memory write data.
REQ-015 Port: core_hold  output  1  high while the loader owns memory; cores SHALL NOT fetch while high.
REQ-016 Port: load_done  output  1  high once both memories are fully written.

Function
REQ-017 States: IDLE, LOAD_D, LOAD_I, DONE; 9-bit word counter cnt.
REQ-018 IDLE: Jen=1 -> LOAD_D with the word on Jin accepted in that cycle as word 0.
REQ-019 A word is accepted on every rising edge where Jen=1 and state is IDLE, LOAD_D, LOAD_I, or DONE (the DONE case is per REQ-025).
REQ-020 Word k (k=0..DEPTH-1) SHALL be written to data memory at address DEPTH-1-k; word DEPTH+k SHALL be written to instruction memory at address DEPTH-1-k (descending fill).
REQ-021 Write latency: one cycle; in the cycle after acceptance, the selected *_we=1 with registered addr/wdata; the other strobe is 0.
REQ-022 Accepting the DEPTH-th data word -> LOAD_I, cnt wraps to 0; accepting the DEPTH-th instruction word -> DONE.
REQ-023 Jen=0 in LOAD_D/LOAD_I: pause; no write, cnt and state hold, core_hold stays 1; the load resumes at the next word when Jen returns to 1.
REQ-024 DONE: load_done=1, core_hold=0, no writes; extra Jen=1 cycles in DONE SHALL be ignored unless REQ-025 applies.
REQ-025 Jen rising edge (0 in the previous cycle, 1 now) in DONE: restart; the word is accepted as word 0, state -> LOAD_D, load_done=0, core_hold=1.
REQ-026 core_hold=1 in IDLE, LOAD_D, LOAD_I; load_done=1 only in DONE.
REQ-027 Jout SHALL register Jin every cycle regardless of state or Jen.

Reset
REQ-028 rst=0 at an edge -> state IDLE, cnt=0, dmem_we=imem_we=0, addrs=0, wdata=0, Jout=0, load_done=0, core_hold=1.
REQ-029 Reset mid-load aborts immediately; no write strobe in the following cycle; a later load restarts at word 0.
REQ-030 Reset has priority over Jen.

Verification
REQ-031 Full load: 1024 cycles Jen=1, Jin=i -> dmem[511-i]=i for i<512, imem[511-(i-512)]=i for i>=512; load_done=1 one cycle after the last word.
REQ-032 Pause: Jen=0 for 5 cycles after word 100 -> no strobes in those cycles; word 101 goes to dmem addr 410.
REQ-033 Boundary: word 511 -> dmem addr 0; word 512 -> imem addr 511 on the next cycle with dmem_we=0.
REQ-034 Reset mid-load at word 300 -> all outputs at reset values the next cycle; reload writes word 0 to dmem addr 511.
REQ-035 Jout: Jin=0xDEADBEEF in cycle n -> Jout=0xDEADBEEF in cycle n+1, both in IDLE and in DONE.
REQ-036 Restart: Jen held at 1 after DONE -> ignored; a Jen 0->1 transition -> load_done=0 and the word is written to dmem addr 511.
